scan_seven_seg: RTL and testbench

Parametrised, time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits.
- Holds a packed BCD/hex value and scans one digit per refresh slot.
- Decodes each nibble to GFEDCBA segments, with optional leading-zero blanking and hex mode.
- Sits between the calculator datapath and the board display pins.
- New values are double-buffered and applied only at frame boundaries, so a frame never tears.

---
 rtl/scan_seven_seg.sv | 149 ++++++++++++++
 tb/tb_scan_seven_seg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/scan_seven_seg.sv
// Time-multiplexed seven-segment driver with a double-buffered display value.
// Define SEVSEG_DP_EN to add the per-digit decimal point (dp_mask in, dp out).
module scan_seven_seg #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
`ifdef SEVSEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    dp,
`endif
  output logic                    pending,
  output logic                    frame_done,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] LAST_CNT = DW'(REFRESH_DIV - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [DW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    tick;
  logic                    wrap;

  logic [3:0]              nib;
  logic                    acc;
  logic [NUM_DIGITS-1:0]   lead;
  logic                    blank;
  logic [6:0]              pattern;
  logic [NUM_DIGITS-1:0]   onehot;

  assign tick = (div_cnt == LAST_CNT);
  assign wrap = tick && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A load on a boundary cycle still swaps the older shadow into disp; the
  // fresh value waits in shadow with pending held for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (load)
        shadow <= value;
      if (wrap && pending)
        disp <= shadow;
      if (load)
        pending <= 1'b1;
      else if (wrap)
        pending <= 1'b0;
    end
  end

  always_comb begin
    nib     = disp[{idx, 2'b00} +: 4];
    acc     = 1'b0;
    lead    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc     = acc | (disp[4*i +: 4] != 4'd0);
      lead[i] = acc;
    end
    blank   = blank_lz && (idx != '0) && !lead[idx];

    case (nib)
      4'h0:    pattern = 7'b0111111;
      4'h1:    pattern = 7'b0000110;
      4'h2:    pattern = 7'b1011011;
      4'h3:    pattern = 7'b1001111;
      4'h4:    pattern = 7'b1100110;
      4'h5:    pattern = 7'b1101101;
      4'h6:    pattern = 7'b1111101;
      4'h7:    pattern = 7'b0000111;
      4'h8:    pattern = 7'b1111111;
      4'h9:    pattern = 7'b1101111;
      4'hA:    pattern = 7'b1110111;
      4'hB:    pattern = 7'b1111100;
      4'hC:    pattern = 7'b0111001;
      4'hD:    pattern = 7'b1011110;
      4'hE:    pattern = 7'b1111001;
      default: pattern = 7'b1110001;
    endcase
    if (nib > 4'd9 && !hex_mode)
      pattern = 7'b0000000;

    onehot      = '0;
    onehot[idx] = 1'b1;
    if (blank) begin
      pattern = 7'b0000000;
      onehot  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= {7{POL}};
      an  <= {NUM_DIGITS{POL}};
    end else begin
      seg <= pattern ^ {7{POL}};
      an  <= onehot ^ {NUM_DIGITS{POL}};
    end
  end

`ifdef SEVSEG_DP_EN
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] disp_dp;

  // The decimal point follows the same double-buffering and ignores blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_dp <= '0;
      disp_dp   <= '0;
      dp        <= POL;
    end else begin
      if (load)
        shadow_dp <= dp_mask;
      if (wrap && pending)
        disp_dp <= shadow_dp;
      dp <= disp_dp[idx] ^ POL;
    end
  end
`endif

endmodule

// File: tb/tb_scan_seven_seg.sv
// Directed self-checking bench for scan_seven_seg (4 digits, 4-cycle slots, active-low).
module tb_scan_seven_seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        hex_mode;
  logic        blank_lz;
  logic        pending;
  logic        frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;
`ifdef SEVSEG_DP_EN
  logic [3:0]  dp_mask = 4'b0000;
  logic        dp;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  scan_seven_seg #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .hex_mode  (hex_mode),
    .blank_lz  (blank_lz),
`ifdef SEVSEG_DP_EN
    .dp_mask   (dp_mask),
    .dp        (dp),
`endif
    .pending   (pending),
    .frame_done(frame_done),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Syncs to a boundary, then checks every cycle of the following frame.
  task automatic check_frame(input string tag, input logic [15:0] an_e, input logic [27:0] seg_e);
    int n;
    int d;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_output({tag, "_sync"}, {31'd0, frame_done}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      step();
      d = (k - 1) / 4;
      check_output($sformatf("%s_an%0d_c%0d", tag, d, k), {28'd0, an}, {28'd0, an_e[4*d +: 4]});
      check_output($sformatf("%s_seg%0d_c%0d", tag, d, k), {25'd0, seg}, {25'd0, seg_e[7*d +: 7]});
      check_output($sformatf("%s_fd_c%0d", tag, k), {31'd0, frame_done}, (k == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    value    = 16'h0000;
    load     = 1'b0;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    step();
    step();
    check_output("rst_seg", {25'd0, seg}, 32'h7F);
    check_output("rst_an", {28'd0, an}, 32'hF);
    check_output("rst_pending", {31'd0, pending}, 32'd0);
    check_output("rst_fd", {31'd0, frame_done}, 32'd0);

    rst = 1'b0;
    n = 0;
    while (an !== 4'b1110 && n < 5) begin
      step();
      n++;
    end
    check_output("first_an", {28'd0, an}, 32'hE);

    apply_stimulus(16'h1234);
    check_output("load_pending", {31'd0, pending}, 32'd1);
    check_frame("scan1234", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19});
    check_output("pending_clear", {31'd0, pending}, 32'd0);

    step();
    step();
    check_output("db_an_a", {28'd0, an}, 32'hE);
    check_output("db_seg_a", {25'd0, seg}, 32'h19);
    apply_stimulus(16'h5678);
    check_output("db_pending_a", {31'd0, pending}, 32'd1);
    check_output("db_an_b", {28'd0, an}, 32'hE);
    check_output("db_seg_b", {25'd0, seg}, 32'h19);
    step();
    step();
    step();
    check_output("db_an_c", {28'd0, an}, 32'hD);
    check_output("db_seg_c", {25'd0, seg}, 32'h30);
    apply_stimulus(16'h9999);
    check_output("db_pending_b", {31'd0, pending}, 32'd1);
    check_output("db_an_d", {28'd0, an}, 32'hD);
    check_output("db_seg_d", {25'd0, seg}, 32'h30);
    check_frame("nines", AN_ALL, {7'h10, 7'h10, 7'h10, 7'h10});
    check_output("db_pending_c", {31'd0, pending}, 32'd0);

    blank_lz = 1'b1;
    apply_stimulus(16'h0012);
    check_frame("lz_on", {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h79, 7'h24});
    blank_lz = 1'b0;
    check_frame("lz_off", AN_ALL, {7'h40, 7'h40, 7'h79, 7'h24});

    blank_lz = 1'b1;
    apply_stimulus(16'h0000);
    check_frame("zero_lz", {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40});

    blank_lz = 1'b0;
    hex_mode = 1'b1;
    apply_stimulus(16'hABCD);
    check_frame("hex_on", AN_ALL, {7'h08, 7'h03, 7'h46, 7'h21});
    hex_mode = 1'b0;
    check_frame("hex_off", AN_ALL, {7'h7F, 7'h7F, 7'h7F, 7'h7F});

    apply_stimulus(16'h4321);
    for (int i = 0; i < 8; i++)
      step();
    check_output("mid_an", {28'd0, an}, 32'hB);
    check_output("mid_pending", {31'd0, pending}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("async_seg", {25'd0, seg}, 32'h7F);
    check_output("async_an", {28'd0, an}, 32'hF);
    check_output("async_pending", {31'd0, pending}, 32'd0);
    check_output("async_fd", {31'd0, frame_done}, 32'd0);
    step();
    step();
    rst = 1'b0;
    check_output("post_rst_pending", {31'd0, pending}, 32'd0);
    check_frame("post_rst", AN_ALL, {7'h40, 7'h40, 7'h40, 7'h40});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
